// File: rtl/spw_sup_pkg.sv
// rtl/spw_sup_pkg.sv - shared encodings for the SpaceWire link supervisor
package spw_sup_pkg;

  typedef enum logic [2:0] {
    SUP_OFF      = 3'd0,
    SUP_START    = 3'd1,
    SUP_WAIT_RUN = 3'd2,
    SUP_RUN      = 3'd3,
    SUP_BACKOFF  = 3'd4,
    SUP_GIVEUP   = 3'd5
  } sup_state_e;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_EVENT  = 2'd2;
  localparam logic [1:0] ADDR_RSVD   = 2'd3;

  localparam int CTRL_ENABLE    = 0;
  localparam int CTRL_AUTOSTART = 1;
  localparam int CTRL_IRQ_EN    = 2;

  localparam int EV_LINK_UP      = 0;
  localparam int EV_LINK_LOST    = 1;
  localparam int EV_ATTEMPT_FAIL = 2;
  localparam int EV_GAVE_UP      = 3;

  localparam int FS_ERROR_RESET = 0;
  localparam int FS_ERROR_WAIT  = 1;
  localparam int FS_READY       = 2;
  localparam int FS_STARTED     = 3;
  localparam int FS_CONNECTING  = 4;
  localparam int FS_RUN         = 5;

endpackage

// File: rtl/spw_sync2.sv
// rtl/spw_sync2.sv - two-flop synchronizer for signals arriving from another clock domain
module spw_sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/spw_link_supervisor.sv
// rtl/spw_link_supervisor.sv - Avalon-MM link bring-up supervisor for the SpaceWire ulight core
module spw_link_supervisor
  import spw_sup_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd2000,
  parameter logic [15:0] BACKOFF_CYCLES = 16'd1000,
  parameter logic [3:0]  MAX_RETRY      = 4'd7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [5:0]  fsm_info,
  output logic        link_start,
  output logic        link_disable,
  output logic        auto_start,
  output logic        irq
);

  logic [5:0]  fs;
  sup_state_e  state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic [3:0]  retry_q, retry_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [3:0]  event_q, event_d;
  logic [3:0]  ev_set, ev_clr;
  logic [31:0] readdata_q, readdata_d;
  logic        link_start_q, link_start_d;
  logic        link_disable_q, link_disable_d;
  logic        auto_start_q, auto_start_d;
  logic        irq_q, irq_d;
  logic        unused_wdata;

  assign unused_wdata = ^writedata[31:4];

  spw_sync2 #(.WIDTH(6)) u_fs_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (fsm_info),
    .q       (fs)
  );

  always_comb begin
    ctrl_d  = ctrl_q;
    state_d = state_q;
    timer_d = timer_q;
    retry_d = retry_q;
    ev_set  = '0;
    ev_clr  = '0;

    if (write && address == ADDR_CTRL) ctrl_d = writedata[2:0];
    if (write && address == ADDR_EVENT) ev_clr = writedata[3:0];

    if (!ctrl_q[CTRL_ENABLE]) begin
      state_d = SUP_OFF;
      retry_d = '0;
    end else begin
      case (state_q)
        SUP_OFF: state_d = SUP_START;
        SUP_START: begin
          timer_d = TIMEOUT_CYCLES - 16'd1;
          state_d = SUP_WAIT_RUN;
        end
        SUP_WAIT_RUN: begin
          if (fs[FS_RUN]) begin
            state_d            = SUP_RUN;
            retry_d            = '0;
            ev_set[EV_LINK_UP] = 1'b1;
          end else if (timer_q == 16'd0) begin
            state_d                 = SUP_BACKOFF;
            timer_d                 = BACKOFF_CYCLES - 16'd1;
            ev_set[EV_ATTEMPT_FAIL] = 1'b1;
            if (retry_q < MAX_RETRY) retry_d = retry_q + 4'd1;
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        SUP_RUN: begin
          if (!fs[FS_RUN]) begin
            state_d              = SUP_START;
            ev_set[EV_LINK_LOST] = 1'b1;
          end
        end
        SUP_BACKOFF: begin
          if (timer_q == 16'd0) begin
            if (retry_q == MAX_RETRY) begin
              state_d            = SUP_GIVEUP;
              ev_set[EV_GAVE_UP] = 1'b1;
            end else begin
              state_d = SUP_START;
            end
          end else begin
            timer_d = timer_q - 16'd1;
          end
        end
        SUP_GIVEUP: state_d = SUP_GIVEUP;
        default:    state_d = SUP_OFF;
      endcase
    end

    // set beats a simultaneous W1C so no hardware event is ever lost
    event_d = (event_q & ~ev_clr) | ev_set;

    // outputs are registered from next-state values so they track state_q glitch-free
    link_start_d   = (state_d == SUP_START) || (state_d == SUP_WAIT_RUN) || (state_d == SUP_RUN);
    link_disable_d = !link_start_d;
    auto_start_d   = ctrl_d[CTRL_AUTOSTART] & ctrl_d[CTRL_ENABLE] &
                     (state_d != SUP_OFF) & (state_d != SUP_GIVEUP);
    irq_d          = ctrl_d[CTRL_IRQ_EN] & (|event_d);

    case (address)
      ADDR_CTRL:   readdata_d = {29'd0, ctrl_q};
      ADDR_STATUS: readdata_d = {19'd0, retry_q, state_q, fs};
      ADDR_EVENT:  readdata_d = {28'd0, event_q};
      default:     readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= SUP_OFF;
      timer_q        <= '0;
      retry_q        <= '0;
      ctrl_q         <= '0;
      event_q        <= '0;
      readdata_q     <= '0;
      link_start_q   <= 1'b0;
      link_disable_q <= 1'b1;
      auto_start_q   <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      retry_q        <= retry_d;
      ctrl_q         <= ctrl_d;
      event_q        <= event_d;
      readdata_q     <= readdata_d;
      link_start_q   <= link_start_d;
      link_disable_q <= link_disable_d;
      auto_start_q   <= auto_start_d;
      irq_q          <= irq_d;
    end
  end

  assign readdata     = readdata_q;
  assign link_start   = link_start_q;
  assign link_disable = link_disable_q;
  assign auto_start   = auto_start_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_spw_link_supervisor.sv
// tb/tb_spw_link_supervisor.sv - directed self-checking bench for spw_link_supervisor
module tb_spw_link_supervisor;

  localparam int T = 20;
  localparam int B = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd1;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [5:0]  fsm_info = 6'd0;
  logic        link_start, link_disable, auto_start, irq;

  int n_assert = 0;
  int n_fail = 0;
  int ls_edges = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  always @(link_start) if (mon_en) ls_edges++;

  spw_link_supervisor #(
    .TIMEOUT_CYCLES (16'd20),
    .BACKOFF_CYCLES (16'd10),
    .MAX_RETRY      (4'd7)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .address      (address),
    .write        (write),
    .writedata    (writedata),
    .readdata     (readdata),
    .fsm_info     (fsm_info),
    .link_start   (link_start),
    .link_disable (link_disable),
    .auto_start   (auto_start),
    .irq          (irq)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a;
    writedata = d;
    write = 1'b1;
    tick(1);
    write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    d = readdata;
  endtask

  initial begin
    logic [31:0] v;
    bit found;

    // reset state
    tick(3);
    chk("rst_readdata", readdata, 32'h0);
    reset_n = 1'b1;
    tick(1);
    chk("rst_link_disable", {31'd0, link_disable}, 32'd1);
    chk("rst_link_start", {31'd0, link_start}, 32'd0);
    chk("rst_auto_start", {31'd0, auto_start}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    rd(2'd1, v);
    chk("rst_status", v, 32'h0);

    // bring-up to RUN with irq enabled
    wr(2'd0, 32'h5);
    tick(1);
    chk("start_link_start", {31'd0, link_start}, 32'd1);
    chk("start_link_disable", {31'd0, link_disable}, 32'd0);
    tick(1);
    fsm_info = 6'h20;
    tick(3);
    chk("run_irq", {31'd0, irq}, 32'd1);
    rd(2'd1, v);
    chk("run_status", v, 32'h0E0);
    rd(2'd2, v);
    chk("run_event", v, 32'h1);
    wr(2'd2, 32'h1);
    chk("w1c_irq_clear", {31'd0, irq}, 32'd0);
    rd(2'd2, v);
    chk("w1c_event", v, 32'h0);

    // link lost with a same-cycle W1C of link_lost
    fsm_info = 6'h01;
    tick(2);
    address = 2'd2;
    writedata = 32'h2;
    write = 1'b1;
    tick(1);
    write = 1'b0;
    chk("lost_link_start", {31'd0, link_start}, 32'd1);
    rd(2'd1, v);
    chk("lost_status_start", v, 32'h041);
    rd(2'd2, v);
    chk("lost_set_wins", v, 32'h2);
    chk("lost_irq", {31'd0, irq}, 32'd1);
    wr(2'd2, 32'h2);
    wr(2'd0, 32'h7);
    chk("auto_start_on", {31'd0, auto_start}, 32'd1);
    wr(2'd0, 32'h0);
    chk("auto_start_off", {31'd0, auto_start}, 32'd0);
    tick(1);
    chk("off_link_start", {31'd0, link_start}, 32'd0);
    chk("off_link_disable", {31'd0, link_disable}, 32'd1);

    // timeout and back-off
    fsm_info = 6'h10;
    tick(3);
    wr(2'd0, 32'h1);
    tick(T + 1);
    chk("timeout_last_wait", {31'd0, link_start}, 32'd1);
    tick(1);
    chk("backoff_link_start", {31'd0, link_start}, 32'd0);
    chk("backoff_link_disable", {31'd0, link_disable}, 32'd1);
    rd(2'd2, v);
    chk("attempt_fail_event", v, 32'h4);
    tick(B - 2);
    chk("backoff_end_low", {31'd0, link_start}, 32'd0);
    tick(1);
    chk("retry_link_start", {31'd0, link_start}, 32'd1);

    // give up after MAX_RETRY failures
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      rd(2'd1, v);
      if (v[8:6] == 3'd5) found = 1'b1;
    end
    chk("giveup_reached", {31'd0, found}, 32'd1);
    chk("giveup_status", v, 32'hF50);
    rd(2'd2, v);
    chk("giveup_event", v, 32'hC);
    chk("giveup_link_start", {31'd0, link_start}, 32'd0);
    chk("giveup_link_disable", {31'd0, link_disable}, 32'd1);
    wr(2'd0, 32'h0);
    tick(1);
    rd(2'd1, v);
    chk("disable_status", v, 32'h010);
    wr(2'd2, 32'hF);

    // asynchronous reset during WAIT_RUN
    fsm_info = 6'h00;
    tick(3);
    wr(2'd0, 32'h1);
    tick(3);
    chk("pre_reset_link_start", {31'd0, link_start}, 32'd1);
    ls_edges = 0;
    mon_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("async_link_start", {31'd0, link_start}, 32'd0);
    chk("async_link_disable", {31'd0, link_disable}, 32'd1);
    chk("async_readdata", readdata, 32'h0);
    tick(2);
    mon_en = 1'b0;
    chk("no_glitch_edges", ls_edges, 32'd1);
    reset_n = 1'b1;
    rd(2'd0, v);
    chk("post_reset_ctrl", v, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
